// File: rtl/coincidence_pkg.sv
// coincidence_pkg
//   Shared types and helpers for the coincidence integrator:
//   - state_t      : integrator FSM states (IDLE, RUN)
//   - COUNT_MAX    : all-ones value for the default 32-bit count width
//   - sat_inc()    : saturating +1 for any count width up to 64 bits
package coincidence_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned COUNT_WIDTH_DEFAULT = 32;
  localparam logic [COUNT_WIDTH_DEFAULT-1:0] COUNT_MAX = '1;

  // Saturating increment. Callers zero-extend their value to 64 bits and
  // pass their real width, so one function serves every counter size.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? max_v : (value + 64'd1);
  endfunction

endpackage

// File: rtl/coincidence_integrator_sat_counter.sv
// sat_counter
//   Clearable counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     clear       : restart from 0 on the next edge (wins over inc)
//     inc         : count this cycle
//     count_next  : saturating count including this cycle's increment,
//                   i.e. the value the register takes when clear is low.
//                   The integrator snapshots this at window end so the
//                   final sample lands in the result.
module sat_counter
  import coincidence_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count_q;
  logic [63:0]      count_ext;
  logic [63:0]      inc_ext;

  always_comb begin
    count_ext             = '0;
    count_ext[WIDTH-1:0]  = count_q;
    inc_ext               = sat_inc(count_ext, WIDTH);
    count_next            = inc ? inc_ext[WIDTH-1:0] : count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/coincidence_integrator.sv
// coincidence_integrator
//   Samples sig_a / sig_b on every tick strobe while running and, over a
//   window of window_len ticks, accumulates per-channel and coincidence
//   (A AND B) counts. Each completed window is offered through a
//   single-entry result register.
//
//   Handshake: a result transfers on any edge where out_valid and out_ready
//   are both 1. out_valid stays high and count_* stay stable until that
//   transfer. A window that ends while a result is held and out_ready is 0
//   is dropped and sets the sticky overrun flag.
//
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     enable              : run control; low returns to IDLE
//     tick                : sample strobe (one-cycle pulses)
//     window_len          : ticks per window, 0 behaves as 1
//     sig_a, sig_b        : channel bits
//     out_ready           : consumer accepts the result
//     out_valid           : result register holds an unconsumed result
//     count_a/_b/_ab      : result counts
//     overrun             : sticky, a completed window was dropped
//     state_dbg           : current FSM state
module coincidence_integrator
  import coincidence_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned WINDOW_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    tick,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  input  logic                    sig_a,
  input  logic                    sig_b,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [COUNT_WIDTH-1:0]  count_a,
  output logic [COUNT_WIDTH-1:0]  count_b,
  output logic [COUNT_WIDTH-1:0]  count_ab,
  output logic                    overrun,
  output state_t                  state_dbg
);

  localparam logic [WINDOW_WIDTH-1:0] WIN_ONE = WINDOW_WIDTH'(1);

  state_t state_q;
  state_t state_next;

  logic running;   // RUN and staying in RUN this cycle
  logic start;     // IDLE -> RUN edge
  logic stop;      // RUN -> IDLE edge

  logic [WINDOW_WIDTH-1:0] tick_cnt;
  logic [WINDOW_WIDTH-1:0] win_q;
  logic [WINDOW_WIDTH-1:0] win_load;

  logic tick_take;
  logic window_end;
  logic acc_clear;
  logic res_load;

  logic [COUNT_WIDTH-1:0] acc_a_next;
  logic [COUNT_WIDTH-1:0] acc_b_next;
  logic [COUNT_WIDTH-1:0] acc_ab_next;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (enable)  state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running   = (state_q == RUN) && enable;
    start     = (state_q == IDLE) && enable;
    stop      = (state_q == RUN) && !enable;
    state_dbg = state_q;
  end

  // ------------------------------------------------------ window control
  // Ticks are taken only in RUN, so a tick on the enable-rise cycle is
  // ignored and a tick on the enable-fall cycle is discarded with the
  // partial window.
  assign tick_take  = running && tick;
  assign window_end = tick_take && (tick_cnt == (win_q - WIN_ONE));
  assign win_load   = (window_len == '0) ? WIN_ONE : window_len;

  // Accumulators sit at zero outside RUN and restart at window end; the
  // window-end sample still reaches the result through count_next.
  assign acc_clear = !running || window_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      win_q    <= '0;
    end else begin
      if (!running || window_end) begin
        tick_cnt <= '0;
      end else if (tick_take) begin
        tick_cnt <= tick_cnt + WIN_ONE;
      end
      if (start || window_end) begin
        win_q <= win_load;
      end
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .inc        (tick_take && sig_a),
    .count_next (acc_a_next)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .inc        (tick_take && sig_b),
    .count_next (acc_b_next)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_acc_ab (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .inc        (tick_take && sig_a && sig_b),
    .count_next (acc_ab_next)
  );

  // ------------------------------------------------------ result register
  // The register is free when empty or when its content leaves this edge,
  // which keeps window_len=1 streaming at one result per tick.
  assign res_load = window_end && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      count_a   <= '0;
      count_b   <= '0;
      count_ab  <= '0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      count_a   <= acc_a_next;
      count_b   <= acc_b_next;
      count_ab  <= acc_ab_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (stop) begin
      overrun <= 1'b0;
    end else if (window_end && out_valid && !out_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: doc/coincidence_integrator.md
# coincidence_integrator

Downstream consumer of the clock divider's `overflow` strobe in the correlator chain. Every strobe cycle it samples two 1-bit channel inputs, and over a programmable window of N strobes it accumulates per-channel and coincidence (A AND B) counts. At window end it hands the three counts to the readout side through a single-entry valid/ready output register.

## Interface
- `COUNT_WIDTH`, 32: width of each accumulated count.
- `WINDOW_WIDTH`, 32: width of the window-length input and the internal tick counter.

- `clk`  in  1  system clock, same domain as the divider.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run control; low forces IDLE.
- `tick`  in  1  sample strobe; divider `overflow`, one-cycle pulses.
- `window_len`  in  WINDOW_WIDTH  ticks per integration window; 0 is treated as 1.
- `sig_a`, `sig_b`  in  1 each  channel bits, already synchronous to `clk`.
- `out_ready`  in  1  consumer accepts the result.
- `out_valid`  out  1  result register holds an unconsumed result.
- `count_a`, `count_b`, `count_ab`  out  COUNT_WIDTH each  result counts.
- `overrun`  out  1  sticky flag: a completed window was dropped.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
- IDLE→RUN when `enable`=1.
  - On that transition, latch `window_len` into `win_q` (0 is replaced by 1).
  - Clear `acc_a`, `acc_b`, `acc_ab` and `tick_cnt`.
- RUN→IDLE when `enable`=0.
  - Accumulators and `tick_cnt` are cleared.
  - `overrun` is cleared.
  - `out_valid` and its result are retained and remain deliverable.
- In RUN, on a cycle with `tick`=1:
  - `acc_a` increments when `sig_a`=1.
  - `acc_b` increments when `sig_b`=1.
  - `acc_ab` increments when both are 1.
  - All three accumulators saturate at 2^COUNT_WIDTH−1; they never wrap.
  - `tick_cnt` increments.
- Window end is a tick cycle where `tick_cnt` = `win_q`−1. On that cycle:
  - The final sample is included in the counts.
  - Accumulator values plus this sample go to the result register.
  - Accumulators and `tick_cnt` restart from 0, with no lost tick.
  - `win_q` reloads from the current `window_len`.
- Output handshake:
  - A transfer occurs on any cycle where `out_valid` and `out_ready` are both 1.
  - `out_valid` stays high and the result stays stable until that transfer.
- Window end when the result register is free, or is freed the same cycle (`out_valid`=1 and `out_ready`=1): the new result is loaded and `out_valid` is 1 next cycle.
- Window end while `out_valid`=1 and `out_ready`=0:
  - The new result is dropped.
  - The held result is untouched.
  - `overrun` is set.
- `tick` in IDLE is ignored.
- `window_len` changes mid-window have no effect until the next window.

## Timing
- Reset values: `out_valid`=0, `count_*`=0, `overrun`=0, state IDLE, all internal counters 0.
- `tick` and `sig_a`/`sig_b` are sampled at the same rising edge.
- Latency: window-end tick sampled at edge T → `out_valid`=1 and the counts are valid after edge T, visible in cycle T+1.
- Back-to-back: with `window_len`=1, every tick produces a result. Zero-wait consumption is sustained when `out_ready` is held at 1.
- First tick accepted is one sampled at least one edge after the IDLE→RUN edge.
  - A tick on the same cycle `enable` rises is ignored.
- `rst` mid-window or with a pending result: all state is cleared immediately, with no output pulse.

## Structure
- Package `coincidence_pkg`:
  - State enum (IDLE, RUN).
  - Saturating-increment function parameterised by width.
  - Constant for COUNT_WIDTH max value.
- Sub-module `sat_counter`, instantiated three times. Ports: clear, increment enable, width parameter, saturating count.
- Top level holds the FSM, `tick_cnt`/`win_q`, the result register and the overrun flag.

## Test plan
- `window_len`=4; `sig_a`=1, `sig_b`=0/1 alternating across 4 ticks; `out_ready`=1 → one result with a=4, b=2, ab=2; `out_valid` high for exactly 1 cycle, the cycle after the 4th tick.
- `window_len`=0; 3 ticks with both inputs 1 → three results, each a=b=ab=1.
- `window_len`=2; `out_ready`=0 through two full windows → the first result is held unchanged and `overrun`=1 after the second window end. Then `out_ready`=1 → one transfer only.
- Window end on the same cycle `out_ready`=1 drains the old result → new result loaded next cycle, `overrun` stays 0.
- COUNT_WIDTH=3, `window_len`=10, inputs held at 1 → a=b=ab=7 (saturated).
- `enable` drops mid-window after 3 of 5 ticks → no result. Re-enable with 5 ticks of `sig_a`=1 → a=5. Also assert `rst` during RUN with `out_valid`=1 → all outputs 0 after the reset edge.
